alu_issue_ctrl: RTL and testbench

Request-side initiator for the ALU → reg_file datapath. Accepts one operation at a time over a valid/ready request channel and drives `R2`/`R3`/`ALUOp` into the ALU. It waits a fixed, parameterised pipeline latency, then captures `R0` and the overflow/zero/carry flags from reg_file. The captured result is presented on a valid/ready response channel, replacing the testbench-style free-running stimulus with a handshaked master.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_issue_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg: opcodes and issue-controller state encoding shared by the   |
// | ALU datapath blocks.                                                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;

  localparam int c_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_ctrl: handshaked initiator that issues one ALU operation,  |
// | waits LAT cycles and returns the reg_file result and flags.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int n   = 32,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [n-1:0] req_a,
  input  logic [n-1:0] req_b,
  output logic [n-1:0] R2,
  output logic [n-1:0] R3,
  output logic [2:0]   ALUOp,
  input  logic [n-1:0] R0,
  input  logic         overflow_in,
  input  logic         zero_in,
  input  logic         carry_in,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [n-1:0] rsp_result,
  output logic         rsp_overflow,
  output logic         rsp_zero,
  output logic         rsp_carry,
  output logic [2:0]   rsp_op,
  output logic [15:0]  ops_done
);

  localparam logic [c_CNT_W-1:0] c_LAT = c_CNT_W'(LAT);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [n-1:0]         r_r2;
  logic [n-1:0]         r_r3;
  logic [2:0]           r_aluop;
  logic [n-1:0]         r_rsp_result;
  logic                 r_rsp_overflow;
  logic                 r_rsp_zero;
  logic                 r_rsp_carry;
  logic [2:0]           r_rsp_op;
  logic [15:0]          r_ops_done;

  logic w_accept;
  logic w_capture;
  logic w_handshake;

  assign req_ready   = (r_state == IDLE);
  assign rsp_valid   = (r_state == RESP);
  assign w_accept    = req_valid && req_ready;
  assign w_capture   = (r_state == WAIT) && (r_cnt == 4'd1);
  assign w_handshake = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_state_nxt = WAIT;
      WAIT:    if (w_capture)   w_state_nxt = RESP;
      RESP:    if (w_handshake) w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // Operand registers only move on accept so the ALU sees a stable
  // operation for the whole latency window and the response phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r2    <= '0;
      r_r3    <= '0;
      r_aluop <= OP_MOV;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_r2    <= req_a;
      r_r3    <= req_b;
      r_aluop <= req_op;
      r_cnt   <= c_LAT;
    end else if (r_state == WAIT) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_rsp_carry    <= 1'b0;
      r_rsp_op       <= OP_MOV;
      r_ops_done     <= '0;
    end else begin
      if (w_capture) begin
        r_rsp_result   <= R0;
        r_rsp_overflow <= overflow_in;
        r_rsp_zero     <= zero_in;
        r_rsp_carry    <= carry_in;
        r_rsp_op       <= r_aluop;
      end
      if (w_handshake) begin
        r_ops_done <= r_ops_done + 16'd1;
      end
    end
  end

  assign R2           = r_r2;
  assign R3           = r_r3;
  assign ALUOp        = r_aluop;
  assign rsp_result   = r_rsp_result;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_carry    = r_rsp_carry;
  assign rsp_op       = r_rsp_op;
  assign ops_done     = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_issue_ctrl: directed bench with a reg_file stand-in and a     |
// | transaction-level reference model.                                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int n   = 32;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = 3'b0;
  logic [n-1:0] req_a = '0;
  logic [n-1:0] req_b = '0;
  logic [n-1:0] R2, R3;
  logic [2:0]   ALUOp;
  logic [n-1:0] R0;
  logic         overflow_in, zero_in, carry_in;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [n-1:0] rsp_result;
  logic         rsp_overflow, rsp_zero, rsp_carry;
  logic [2:0]   rsp_op;
  logic [15:0]  ops_done;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue_ctrl #(.n(n), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .R2(R2), .R3(R3), .ALUOp(ALUOp),
    .R0(R0), .overflow_in(overflow_in), .zero_in(zero_in), .carry_in(carry_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .rsp_op(rsp_op), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  // {overflow, zero, carry, result}; SUB carry is the borrow out.
  function automatic logic [n+2:0] alu(input logic [2:0] op, input logic [n-1:0] a, b);
    logic [n:0]   wide;
    logic [n-1:0] r;
    logic         c, ov;
    wide = '0; c = 1'b0; ov = 1'b0;
    case (op)
      OP_MOV:  r = a;
      OP_NOT:  r = ~a;
      OP_ADD:  begin wide = {1'b0, a} + {1'b0, b}; r = wide[n-1:0]; c = wide[n];
                     ov = (a[n-1] == b[n-1]) && (r[n-1] != a[n-1]); end
      OP_NOR:  r = ~(a | b);
      OP_SUB:  begin wide = {1'b0, a} - {1'b0, b}; r = wide[n-1:0]; c = wide[n];
                     ov = (a[n-1] != b[n-1]) && (r[n-1] != a[n-1]); end
      OP_NAND: r = ~(a & b);
      default: r = '0;
    endcase
    return {ov, (r == '0), c, r};
  endfunction

  // reg_file stand-in: one register after the ALU gives a LAT=2 path.
  logic [n+2:0] rf_q = '0;
  always @(posedge clk) rf_q <= alu(ALUOp, R2, R3);
  assign {overflow_in, zero_in, carry_in, R0} = rf_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: what should be visible after each edge.
  int           cyc = 0;
  bit           m_inflight = 0, m_have = 0;
  int           m_acc = 0;
  logic [2:0]   m_op = '0;
  logic [n-1:0] m_a = '0, m_b = '0;
  logic [n-1:0] e_r2 = '0, e_r3 = '0, e_res = '0;
  logic [2:0]   e_aluop = '0, e_op = '0;
  logic         e_ov = 0, e_z = 0, e_c = 0;
  int           e_ops = 0;
  bit           model_on = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_inflight = 0; m_have = 0;
      e_r2 = '0; e_r3 = '0; e_aluop = '0;
      e_res = '0; e_ov = 0; e_z = 0; e_c = 0; e_op = '0; e_ops = 0;
    end else if (m_have) begin
      if (rsp_ready) begin
        m_have = 0;
        e_ops = (e_ops + 1) % 65536;
      end
    end else if (m_inflight) begin
      if (cyc == m_acc + LAT) begin
        {e_ov, e_z, e_c, e_res} = alu(m_op, m_a, m_b);
        e_op = m_op; m_have = 1; m_inflight = 0;
      end
    end else if (req_valid) begin
      m_inflight = 1; m_acc = cyc;
      m_op = req_op; m_a = req_a; m_b = req_b;
      e_r2 = req_a; e_r3 = req_b; e_aluop = req_op;
    end
    model_on = 1;
  end

  always @(posedge clk) begin
    #1;
    if (model_on) begin
      chk("req_ready",    req_ready,    !(m_inflight || m_have));
      chk("rsp_valid",    rsp_valid,    m_have);
      chk("R2",           R2,           e_r2);
      chk("R3",           R3,           e_r3);
      chk("ALUOp",        ALUOp,        e_aluop);
      chk("rsp_result",   rsp_result,   e_res);
      chk("rsp_flags",    {rsp_overflow, rsp_zero, rsp_carry}, {e_ov, e_z, e_c});
      chk("rsp_op",       rsp_op,       e_op);
      chk("ops_done",     ops_done,     64'(e_ops));
    end
  end

  // Call at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [n-1:0] a, b);
    int k;
    req_valid = 1; req_op = op; req_a = a; req_b = b;
    k = 0;
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    if (!req_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_rsp;
    int k;
    k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    chk("rsp_latency", 64'(k), 64'(LAT));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_ALUOp", ALUOp, 3'b000);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ops_done", ops_done, 0);
    rst = 0;
    @(negedge clk);

    issue(OP_ADD, 32'd1000, 32'd999);
    wait_rsp();
    chk("add_small_res", rsp_result, 32'd1999);
    chk("add_small_flags", {rsp_overflow, rsp_zero, rsp_carry}, 3'b000);
    @(negedge clk);
    chk("ops_done_1", ops_done, 16'd1);

    issue(OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_rsp();
    chk("add_max_res", rsp_result, 32'hFFFF_FFFE);
    chk("add_max_flags", {rsp_overflow, rsp_zero, rsp_carry}, 3'b001);
    @(negedge clk);

    issue(OP_SUB, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_rsp();
    chk("sub_eq_res", rsp_result, 32'h0);
    chk("sub_eq_zero", rsp_zero, 1);
    chk("sub_eq_op", rsp_op, 3'b100);
    @(negedge clk);

    issue(OP_NAND, 32'hF0F0_1234, 32'h0FF0_FFFF);
    wait_rsp(); @(negedge clk);
    issue(OP_NOR, 32'h0000_00FF, 32'h0F00_0000);
    wait_rsp(); @(negedge clk);
    issue(OP_NOT, 32'hA5A5_A5A5, 32'h0);
    wait_rsp(); @(negedge clk);

    // Backpressure with a second request already waiting.
    rsp_ready = 0;
    issue(OP_ADD, 32'h11, 32'h22);
    wait_rsp();
    req_valid = 1; req_op = OP_SUB; req_a = 32'h50; req_b = 32'h7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_R2_hold", R2, 32'h11);
      chk("bp_result_hold", rsp_result, 32'h33);
    end
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_ready_after_hs", req_ready, 1);
    chk("bp_R2_before_accept", R2, 32'h11);
    @(posedge clk);
    #1;
    chk("bp_R2_accepted", R2, 32'h50);
    chk("bp_ALUOp_accepted", ALUOp, OP_SUB);
    @(negedge clk);
    req_valid = 0;
    wait_rsp();
    chk("bp_second_res", rsp_result, 32'h49);
    @(negedge clk);

    // Reset while waiting on the ALU.
    issue(OP_ADD, 32'd5, 32'd6);
    rst = 1;
    #1;
    chk("rstw_rsp_valid", rsp_valid, 0);
    chk("rstw_req_ready", req_ready, 1);
    chk("rstw_R2", R2, 0);
    chk("rstw_ops_done", ops_done, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstw_no_rsp", rsp_valid, 0);
    end
    issue(OP_MOV, 32'h1234_5678, 32'h0);
    wait_rsp();
    chk("post_rst_res", rsp_result, 32'h1234_5678);
    chk("post_rst_op", rsp_op, OP_MOV);
    @(negedge clk);
    chk("post_rst_ops_done", ops_done, 16'd1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
